// File: rtl/riscv_defs_pkg.sv
// Shared definitions for the fetch path: FSM state encoding, the NOP word and the default XLEN.
package riscv_defs;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Fetch buffer holding DEPTH entries of {[fault,] pc, instr}; a synchronous clear beats push and
// pop.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear && !reset) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding imem read, buffered {pc, instr} to decode over valid/ready.
// Optional misaligned-PC check enabled by defining FETCH_MISALIGN_CHK_EN.
module instr_fetch_unit
  import riscv_defs::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_advance,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [XLEN-1:0]   instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              fetch_fault
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
`ifdef FETCH_MISALIGN_CHK_EN
  localparam int unsigned EW = 1 + ADDR_W + XLEN;
`else
  localparam int unsigned EW = ADDR_W + XLEN;
`endif

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty, space;
  logic [CW-1:0]     fifo_count;
  logic [EW-1:0]     fifo_wdata, fifo_rdata;
  logic [ADDR_W-1:0] push_pc;
  logic [XLEN-1:0]   push_instr;
`ifdef FETCH_MISALIGN_CHK_EN
  logic              push_fault;
`endif

  assign space = (fifo_count < CW'(DEPTH));

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    pc_advance = 1'b0;
    fifo_push  = 1'b0;
    push_pc    = pc_q;
    push_instr = imem_rdata;
`ifdef FETCH_MISALIGN_CHK_EN
    push_fault = 1'b0;
`endif
    unique case (state_q)
      IF_IDLE: begin
        if (!flush && space) begin
`ifdef FETCH_MISALIGN_CHK_EN
          // Misaligned PC: never reaches memory, a faulting NOP is queued instead.
          if (pc_in[1:0] != 2'b00) begin
            fifo_push  = 1'b1;
            push_fault = 1'b1;
            push_pc    = pc_in;
            push_instr = XLEN'(NOP);
            pc_advance = 1'b1;
          end else
`endif
          begin
            imem_req   = 1'b1;
            pc_advance = 1'b1;
            state_d    = IF_WAIT;
          end
        end
      end
      IF_WAIT: begin
        if (imem_rvalid) begin
          fifo_push = !flush;
          state_d   = IF_IDLE;
        end else if (flush) begin
          state_d = IF_DROP;
        end
      end
      IF_DROP: begin
        if (imem_rvalid) state_d = IF_IDLE;
      end
      default: state_d = IF_IDLE;
    endcase
    if (reset) begin
      imem_req   = 1'b0;
      pc_advance = 1'b0;
      fifo_push  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IF_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (imem_req) pc_q <= pc_in;
    end
  end

  assign imem_addr = imem_req ? pc_in : '0;
  assign fifo_pop  = instr_valid && instr_ready;

`ifdef FETCH_MISALIGN_CHK_EN
  assign fifo_wdata  = {push_fault, push_pc, push_instr};
  assign fetch_fault = !fifo_empty && fifo_rdata[EW-1];
`else
  assign fifo_wdata  = {push_pc, push_instr};
  assign fetch_fault = 1'b0;
`endif

  assign instr_valid = !fifo_empty;
  assign instr_data  = fifo_empty ? '0 : fifo_rdata[XLEN-1:0];
  assign instr_pc    = fifo_empty ? '0 : fifo_rdata[XLEN +: ADDR_W];

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (flush),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Issue is gated on space and nothing else pushes while a read is in flight.
  assert property (@(posedge clk) disable iff (reset) !(fifo_push && fifo_full));

endmodule
